// File: rtl/spi_memory_master.sv
// SPI mode-0 memory master: cmd, optional address, optional dummy clocks, then N data bytes.
// Optional SPI_MEMORY_MASTER_ABORT_EN adds abort/aborted for cutting a transfer short.
module spi_memory_master #(
    parameter int ADDR_BYTES   = 3,
    parameter int DUMMY_CYCLES = 8,
    parameter int HALF_DIV     = 2
) (
    input  logic                    main_clock,
    input  logic                    rst_n,
    output logic                    sck,
    output logic                    cs,
    output logic                    mosi,
    input  logic                    miso,
    input  logic                    start,
    input  logic [7:0]              cmd,
    input  logic [ADDR_BYTES*8-1:0] addr,
    input  logic                    use_addr,
    input  logic                    use_dummy,
    input  logic                    rw,
    input  logic [15:0]             len,
    input  logic [7:0]              wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [7:0]              rd_data,
    output logic                    rd_valid,
    output logic                    busy,
    output logic                    done
`ifdef SPI_MEMORY_MASTER_ABORT_EN
   ,input  logic                    abort
   ,output logic                    aborted
`endif
);

    localparam int SW   = ADDR_BYTES * 8;
    localparam int MAXB = (SW > DUMMY_CYCLES) ? SW : DUMMY_CYCLES;
    localparam int BW   = $clog2(MAXB + 1);
    localparam int HW   = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [HW-1:0] HALF_LOAD = HW'(HALF_DIV - 1);

    // state | meaning
    // IDLE  | waiting for start, cs high
    // SETUP | first low half before cmd bit 7 rises
    // CMD   | shifting command byte
    // ADDR  | shifting address, MSB first
    // DUMMY | free-running clocks, mosi low
    // WDATA | write bytes; stalls sck low while wr_ready is up
    // RDATA | read bytes, one rd_valid per byte
    // HOLD  | sck low half before releasing cs
    // DONE  | done pulse, back to IDLE
    typedef enum logic [3:0] {
        IDLE, SETUP, CMD, ADDR, DUMMY, WDATA, RDATA, HOLD, DONE
    } state_t;

    state_t state, state_d, nxt;
    state_t after_cmd, after_addr, after_dummy;

    logic                    sck_d, cs_d, mosi_d, wr_ready_d, rd_valid_d, busy_d, done_d;
    logic [7:0]              rd_data_d;
    logic [HW-1:0]           half_cnt, half_d;
    logic [BW-1:0]           bits_left, bits_d;
    logic [15:0]             byte_cnt, bytes_d;
    logic [SW-1:0]           tx, tx_d;
    logic [7:0]              rx, rx_d;
    logic [ADDR_BYTES*8-1:0] addr_q, addr_d;
    logic                    use_addr_q, use_addr_d, use_dummy_q, use_dummy_d, rw_q, rw_d;
`ifdef SPI_MEMORY_MASTER_ABORT_EN
    logic                    abort_pend, abort_pend_d, aborted_d;
`endif

    // byte_cnt still holds len until the data phase starts
    assign after_dummy = (byte_cnt == 16'd0) ? HOLD : (rw_q ? RDATA : WDATA);
    assign after_addr  = use_dummy_q ? DUMMY : after_dummy;
    assign after_cmd   = use_addr_q ? ADDR : after_addr;

    always_comb begin
        state_d     = state;
        nxt         = state;
        sck_d       = sck;
        cs_d        = cs;
        mosi_d      = mosi;
        wr_ready_d  = wr_ready;
        rd_data_d   = rd_data;
        rd_valid_d  = 1'b0;
        busy_d      = busy;
        done_d      = 1'b0;
        half_d      = half_cnt;
        bits_d      = bits_left;
        bytes_d     = byte_cnt;
        tx_d        = tx;
        rx_d        = rx;
        addr_d      = addr_q;
        use_addr_d  = use_addr_q;
        use_dummy_d = use_dummy_q;
        rw_d        = rw_q;
`ifdef SPI_MEMORY_MASTER_ABORT_EN
        abort_pend_d = abort_pend;
        aborted_d    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    addr_d      = addr;
                    use_addr_d  = use_addr;
                    use_dummy_d = use_dummy;
                    rw_d        = rw;
                    bytes_d     = len;
                    tx_d        = SW'(cmd) << (SW - 8);
                    mosi_d      = cmd[7];
                    bits_d      = BW'(8);
                    half_d      = HALF_LOAD;
                    cs_d        = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = SETUP;
`ifdef SPI_MEMORY_MASTER_ABORT_EN
                    abort_pend_d = 1'b0;
`endif
                end
            end
            SETUP: begin
                if (half_cnt == '0) begin
                    sck_d   = 1'b1;
                    half_d  = HALF_LOAD;
                    state_d = CMD;
                end else begin
                    half_d = half_cnt - HW'(1);
                end
            end
            CMD, ADDR, DUMMY, WDATA, RDATA: begin
                if (state == WDATA && wr_ready) begin
                    if (wr_valid) begin
                        tx_d       = SW'(wr_data) << (SW - 8);
                        mosi_d     = wr_data[7];
                        wr_ready_d = 1'b0;
                        half_d     = HALF_LOAD;
                        bits_d     = BW'(8);
                    end
                end else if (half_cnt != '0) begin
                    half_d = half_cnt - HW'(1);
                end else begin
                    half_d = HALF_LOAD;
                    if (!sck) begin
                        sck_d = 1'b1;
                        if (state == RDATA) begin
                            rx_d = {rx[6:0], miso};
                            if (bits_left == BW'(1)) begin
                                rd_data_d  = {rx[6:0], miso};
                                rd_valid_d = 1'b1;
                            end
                        end
                    end else begin
                        sck_d = 1'b0;
                        if (bits_left != BW'(1)) begin
                            bits_d = bits_left - BW'(1);
                            tx_d   = tx << 1;
                            mosi_d = tx[SW-2];
                        end else begin
                            case (state)
                                CMD:     nxt = after_cmd;
                                ADDR:    nxt = after_addr;
                                DUMMY:   nxt = after_dummy;
                                default: begin
                                    bytes_d = byte_cnt - 16'd1;
                                    nxt     = (byte_cnt == 16'd1) ? HOLD : state;
                                end
                            endcase
                            state_d = nxt;
                            mosi_d  = 1'b0;
                            tx_d    = '0;
                            case (nxt)
                                ADDR: begin
                                    tx_d   = addr_q;
                                    mosi_d = addr_q[SW-1];
                                    bits_d = BW'(SW);
                                end
                                DUMMY:   bits_d = BW'(DUMMY_CYCLES);
                                RDATA:   bits_d = BW'(8);
                                WDATA:   wr_ready_d = 1'b1;
                                default: ;
                            endcase
                        end
                    end
                end
            end
            HOLD: begin
                if (half_cnt == '0) begin
                    cs_d    = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
`ifdef SPI_MEMORY_MASTER_ABORT_EN
                    aborted_d    = abort_pend;
                    abort_pend_d = 1'b0;
`endif
                end else begin
                    half_d = half_cnt - HW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef SPI_MEMORY_MASTER_ABORT_EN
        // abort overrides everything, including a byte completing this cycle
        if (abort && busy && state != DONE) begin
            state_d      = HOLD;
            sck_d        = 1'b0;
            mosi_d       = 1'b0;
            half_d       = HALF_LOAD;
            wr_ready_d   = 1'b0;
            rd_valid_d   = 1'b0;
            rd_data_d    = rd_data;
            cs_d         = 1'b0;
            busy_d       = 1'b1;
            done_d       = 1'b0;
            aborted_d    = 1'b0;
            abort_pend_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge main_clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sck         <= 1'b0;
            cs          <= 1'b1;
            mosi        <= 1'b0;
            wr_ready    <= 1'b0;
            rd_data     <= 8'h00;
            rd_valid    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            half_cnt    <= '0;
            bits_left   <= '0;
            byte_cnt    <= 16'd0;
            tx          <= '0;
            rx          <= 8'h00;
            addr_q      <= '0;
            use_addr_q  <= 1'b0;
            use_dummy_q <= 1'b0;
            rw_q        <= 1'b0;
`ifdef SPI_MEMORY_MASTER_ABORT_EN
            abort_pend  <= 1'b0;
            aborted     <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            sck         <= sck_d;
            cs          <= cs_d;
            mosi        <= mosi_d;
            wr_ready    <= wr_ready_d;
            rd_data     <= rd_data_d;
            rd_valid    <= rd_valid_d;
            busy        <= busy_d;
            done        <= done_d;
            half_cnt    <= half_d;
            bits_left   <= bits_d;
            byte_cnt    <= bytes_d;
            tx          <= tx_d;
            rx          <= rx_d;
            addr_q      <= addr_d;
            use_addr_q  <= use_addr_d;
            use_dummy_q <= use_dummy_d;
            rw_q        <= rw_d;
`ifdef SPI_MEMORY_MASTER_ABORT_EN
            abort_pend  <= abort_pend_d;
            aborted     <= aborted_d;
`endif
        end
    end

endmodule

// File: tb/tb_spi_memory_master.sv
// Directed bench for spi_memory_master: a negedge monitor plays the SPI slave and records
// SCK rises, MOSI bits, read bytes and done pulses; scenario tasks compare against hand values.
module tb_spi_memory_master;

    logic        main_clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck, cs, mosi, wr_ready, rd_valid, busy, done;
    logic        miso = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cmd = 8'h00;
    logic [23:0] addr = 24'h0;
    logic        use_addr = 1'b0, use_dummy = 1'b0, rw = 1'b0;
    logic [15:0] len = 16'd0;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_valid = 1'b0;
    logic [7:0]  rd_data;
`ifdef SPI_MEMORY_MASTER_ABORT_EN
    logic        abort = 1'b0;
    logic        aborted;
`endif

    int errors = 0;
    int checks = 0;

    // slave / monitor state
    logic [63:0] miso_stream = 64'h0;
    logic [63:0] mosi_cap = 64'h0;
    logic [63:0] last_mosi = 64'h0;
    logic        sck_prev = 1'b0;
    int          rise_cnt = 0;
    int          total_rises = 0;
    int          last_rises = 0;
    int          done_cnt = 0;
    int          abort_done_cnt = 0;
    int          rd_n = 0;
    logic [7:0]  rd_hist [0:15];
    logic [7:0]  wbuf [0:3];
    int          wlen = 0;

    spi_memory_master dut (
        .main_clock (main_clock),
        .rst_n      (rst_n),
        .sck        (sck),
        .cs         (cs),
        .mosi       (mosi),
        .miso       (miso),
        .start      (start),
        .cmd        (cmd),
        .addr       (addr),
        .use_addr   (use_addr),
        .use_dummy  (use_dummy),
        .rw         (rw),
        .len        (len),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .done       (done)
`ifdef SPI_MEMORY_MASTER_ABORT_EN
       ,.abort      (abort)
       ,.aborted    (aborted)
`endif
    );

    always #5 main_clock = ~main_clock;

    always @(negedge main_clock) begin
        if (!sck_prev && sck) begin
            rise_cnt    = rise_cnt + 1;
            total_rises = total_rises + 1;
            mosi_cap    = {mosi_cap[62:0], mosi};
        end
        sck_prev = sck;
        if (rd_valid) begin
            rd_hist[rd_n % 16] = rd_data;
            rd_n = rd_n + 1;
        end
        if (done) begin
            done_cnt   = done_cnt + 1;
            last_rises = rise_cnt;
            last_mosi  = mosi_cap;
`ifdef SPI_MEMORY_MASTER_ABORT_EN
            if (aborted) abort_done_cnt = abort_done_cnt + 1;
`endif
        end
        if (cs) begin
            rise_cnt = 0;
            mosi_cap = 64'h0;
        end
        if (!sck) miso = (rise_cnt < 64) ? miso_stream[63 - rise_cnt] : 1'b0;
    end

    task automatic launch(input logic [7:0] c, input logic [23:0] a, input logic ua,
                          input logic ud, input logic r, input logic [15:0] n);
        @(posedge main_clock); #1;
        cmd = c; addr = a; use_addr = ua; use_dummy = ud; rw = r; len = n;
        start = 1'b1;
        @(posedge main_clock); #1;
        start = 1'b0;
    endtask

    // feeds wbuf[0..wlen-1] whenever wr_ready is up; returns when a done pulse is seen
    task automatic run_xfer(input int budget, output logic ok);
        int base = done_cnt;
        int wi = 0;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge main_clock); #1;
            if (wr_valid) begin
                wr_valid = 1'b0;
                wi = wi + 1;
            end
            if (wr_ready && wi < wlen) begin
                wr_valid = 1'b1;
                wr_data  = wbuf[wi];
            end
            if (done_cnt != base) begin
                ok = 1'b1;
                break;
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge main_clock);
        #1;
        checks++;
        if ({sck, cs, mosi, wr_ready, rd_valid, busy, done} !== 7'b0100000) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0100000", {sck, cs, mosi, wr_ready, rd_valid, busy, done});
        end
        checks++;
        if (rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rd_data got %h want 00", rd_data);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge main_clock);
        #1;
        checks++;
        if ({cs, busy, sck} !== 3'b100) begin
            errors++;
            $display("FAIL idle_after_reset got %b want 100", {cs, busy, sck});
        end
    endtask

    task automatic test_read_id();
        int   base_rd = rd_n;
        int   base_done = done_cnt;
        logic ok;
        miso_stream = 64'h00EF4018_00000000;
        wlen = 0;
        launch(8'h9F, 24'h0, 1'b0, 1'b0, 1'b1, 16'd3);
        checks++;
        if ({busy, cs} !== 2'b10) begin
            errors++;
            $display("FAIL read_busy_cs got %b want 10", {busy, cs});
        end
        run_xfer(1000, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL read_timeout got no done want done");
        end
        repeat (4) @(posedge main_clock);
        #1;
        checks++;
        if (last_rises !== 32) begin
            errors++;
            $display("FAIL read_sck_count got %0d want 32", last_rises);
        end
        checks++;
        if (rd_n - base_rd !== 3) begin
            errors++;
            $display("FAIL read_valid_count got %0d want 3", rd_n - base_rd);
        end
        checks++;
        if ({rd_hist[base_rd % 16], rd_hist[(base_rd + 1) % 16], rd_hist[(base_rd + 2) % 16]} !== 24'hEF4018) begin
            errors++;
            $display("FAIL read_bytes got %h%h%h want ef4018", rd_hist[base_rd % 16],
                     rd_hist[(base_rd + 1) % 16], rd_hist[(base_rd + 2) % 16]);
        end
        checks++;
        if (done_cnt - base_done !== 1) begin
            errors++;
            $display("FAIL read_done_once got %0d want 1", done_cnt - base_done);
        end
        checks++;
        if (last_mosi[31:0] !== 32'h9F000000) begin
            errors++;
            $display("FAIL read_mosi got %h want 9f000000", last_mosi[31:0]);
        end
        checks++;
        if ({busy, cs} !== 2'b01) begin
            errors++;
            $display("FAIL read_end_busy_cs got %b want 01", {busy, cs});
        end
    endtask

    task automatic test_write();
        int   base_rd = rd_n;
        logic ok;
        miso_stream = 64'h0;
        wbuf[0] = 8'hA5; wbuf[1] = 8'h5A; wlen = 2;
        launch(8'h02, 24'h012345, 1'b1, 1'b0, 1'b0, 16'd2);
        run_xfer(1000, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL write_timeout got no done want done");
        end
        checks++;
        if (last_rises !== 48) begin
            errors++;
            $display("FAIL write_sck_count got %0d want 48", last_rises);
        end
        checks++;
        if (last_mosi[47:0] !== 48'h02012345A55A) begin
            errors++;
            $display("FAIL write_mosi got %h want 02012345a55a", last_mosi[47:0]);
        end
        checks++;
        if (rd_n !== base_rd) begin
            errors++;
            $display("FAIL write_no_rd_valid got %0d want %0d", rd_n, base_rd);
        end
    endtask

    task automatic test_write_stall();
        int   base_rises;
        logic seen = 1'b0;
        logic ok;
        wbuf[0] = 8'hC3; wlen = 1;
        launch(8'h02, 24'h0, 1'b0, 1'b0, 1'b0, 16'd1);
        for (int c = 0; c < 200; c++) begin
            @(posedge main_clock); #1;
            if (wr_ready) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL stall_wr_ready_timeout got 0 want 1");
        end
        base_rises = total_rises;
        repeat (20) @(posedge main_clock);
        #1;
        checks++;
        if ({sck, cs, wr_ready} !== 3'b001) begin
            errors++;
            $display("FAIL stall_pins got %b want 001", {sck, cs, wr_ready});
        end
        checks++;
        if (total_rises !== base_rises) begin
            errors++;
            $display("FAIL stall_no_edges got %0d want %0d", total_rises, base_rises);
        end
        run_xfer(500, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL stall_timeout got no done want done");
        end
        checks++;
        if ({last_rises[7:0], last_mosi[15:0]} !== {8'd16, 16'h02C3}) begin
            errors++;
            $display("FAIL stall_resume got %0d/%h want 16/02c3", last_rises, last_mosi[15:0]);
        end
    endtask

    task automatic test_fast_read();
        int   base_rd = rd_n;
        logic ok;
        miso_stream = 64'h00000000_003C0000;
        wlen = 0;
        launch(8'h0B, 24'h000100, 1'b1, 1'b1, 1'b1, 16'd1);
        run_xfer(1000, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL fast_timeout got no done want done");
        end
        checks++;
        if (last_rises !== 48) begin
            errors++;
            $display("FAIL fast_sck_count got %0d want 48", last_rises);
        end
        checks++;
        if (last_mosi[47:0] !== 48'h0B0001000000) begin
            errors++;
            $display("FAIL fast_mosi got %h want 0b0001000000", last_mosi[47:0]);
        end
        checks++;
        if (rd_n - base_rd !== 1 || rd_hist[base_rd % 16] !== 8'h3C) begin
            errors++;
            $display("FAIL fast_rd_data got %0d/%h want 1/3c", rd_n - base_rd, rd_hist[base_rd % 16]);
        end
    endtask

    task automatic test_reset_mid();
        int   base_rd = rd_n;
        int   base_done = done_cnt;
        int   base_rises = total_rises;
        logic reached = 1'b0;
        logic ok;
        miso_stream = 64'h00EF4018_00000000;
        wlen = 0;
        launch(8'h9F, 24'h0, 1'b0, 1'b0, 1'b1, 16'd3);
        for (int c = 0; c < 300; c++) begin
            @(posedge main_clock); #1;
            if (total_rises - base_rises >= 12) begin
                reached = 1'b1;
                break;
            end
        end
        checks++;
        if (reached !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_reach_timeout got 0 want 1");
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({cs, sck, busy} !== 3'b100) begin
            errors++;
            $display("FAIL rstmid_async got %b want 100", {cs, sck, busy});
        end
        repeat (2) @(posedge main_clock);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge main_clock);
        #1;
        checks++;
        if (done_cnt !== base_done || rd_n !== base_rd) begin
            errors++;
            $display("FAIL rstmid_no_done got %0d/%0d want %0d/%0d", done_cnt, rd_n, base_done, base_rd);
        end
        miso_stream = 64'h00A70000_00000000;
        base_rd = rd_n;
        launch(8'h9F, 24'h0, 1'b0, 1'b0, 1'b1, 16'd1);
        run_xfer(500, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_restart_timeout got no done want done");
        end
        checks++;
        if (last_rises !== 16 || rd_hist[base_rd % 16] !== 8'hA7) begin
            errors++;
            $display("FAIL rstmid_restart got %0d/%h want 16/a7", last_rises, rd_hist[base_rd % 16]);
        end
    endtask

`ifdef SPI_MEMORY_MASTER_ABORT_EN
    task automatic test_abort();
        int   base_rd = rd_n;
        int   base_ad = abort_done_cnt;
        int   base_rises = total_rises;
        logic ok;
        miso_stream = 64'h00EF4018_00000000;
        wlen = 0;
        launch(8'h9F, 24'h0, 1'b0, 1'b0, 1'b1, 16'd2);
        for (int c = 0; c < 300; c++) begin
            @(posedge main_clock); #1;
            if (total_rises - base_rises >= 13) break;
        end
        abort = 1'b1;
        @(posedge main_clock); #1;
        abort = 1'b0;
        checks++;
        if ({sck, cs} !== 2'b00) begin
            errors++;
            $display("FAIL abort_sck_low got %b want 00", {sck, cs});
        end
        run_xfer(50, ok);
        checks++;
        if (ok !== 1'b1 || abort_done_cnt - base_ad !== 1) begin
            errors++;
            $display("FAIL abort_done_aborted got %b/%0d want 1/1", ok, abort_done_cnt - base_ad);
        end
        checks++;
        if (rd_n !== base_rd) begin
            errors++;
            $display("FAIL abort_no_rd_valid got %0d want %0d", rd_n, base_rd);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read_id();
        test_write();
        test_write_stall();
        test_fast_read();
        test_reset_mid();
`ifdef SPI_MEMORY_MASTER_ABORT_EN
        test_abort();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
